// File: rtl/card_shoe.sv
// card_shoe: single 52-card blackjack shoe, one card per draw request, no repeats until refilled.
// Build with SCRIPTED_DECK_EN defined to deal a fixed 8-card script instead of the LFSR shoe.
module card_shoe #(
  parameter logic [15:0] SEED           = 16'hACE1,
  parameter bit          AUTO_RESHUFFLE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       shuffle,
  output logic       card_valid,
  output logic [5:0] card_value,
  output logic [3:0] card_rank,
  output logic [1:0] card_suit,
  output logic       busy,
  output logic [5:0] cards_left,
  output logic       reshuffled
);
  typedef enum logic [1:0] {IDLE = 2'd0, PROBE = 2'd1, DELIVER = 2'd2} state_t;

  state_t      state_r, state_s;
  logic [15:0] lfsr_r;
  logic [5:0]  cand_s;
  logic [5:0]  idx_r, idx_s;
  logic [51:0] mask_r, mask_s;
  logic [5:0]  left_r, left_s;
  logic [3:0]  pend_rank_r, pend_rank_s;
  logic [1:0]  pend_suit_r, pend_suit_s;
  logic [5:0]  pend_value_r, pend_value_s;
  logic [3:0]  rank_r, rank_s;
  logic [1:0]  suit_r, suit_s;
  logic [5:0]  value_r, value_s;
  logic        valid_r, valid_s;
  logic        busy_r, busy_s;
  logic        resh_r, resh_s;
`ifdef SCRIPTED_DECK_EN
  logic [2:0]  ptr_r, ptr_s;
`endif

  function automatic logic [1:0] suit_of(input logic [5:0] idx);
    logic [1:0] s;
    if (idx >= 6'd39) s = 2'd3;
    else if (idx >= 6'd26) s = 2'd2;
    else if (idx >= 6'd13) s = 2'd1;
    else s = 2'd0;
    return s;
  endfunction

  function automatic logic [3:0] rank_of(input logic [5:0] idx);
    return 4'(idx - (6'd13 * {4'd0, suit_of(idx)}) + 6'd1);
  endfunction

  function automatic logic [5:0] value_of(input logic [3:0] rank);
    logic [5:0] v;
    if (rank == 4'd1) v = 6'd11;
    else if (rank >= 4'd11) v = 6'd10;
    else v = {2'b00, rank};
    return v;
  endfunction

`ifdef SCRIPTED_DECK_EN
  function automatic logic [5:0] script_value(input logic [2:0] ptr);
    logic [5:0] v;
    case (ptr)
      3'd0:    v = 6'd10;
      3'd1:    v = 6'd8;
      3'd2:    v = 6'd4;
      3'd3:    v = 6'd10;
      3'd4:    v = 6'd8;
      3'd5:    v = 6'd2;
      3'd6:    v = 6'd10;
      3'd7:    v = 6'd11;
      default: v = 6'd10;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] script_rank(input logic [2:0] ptr);
    return (script_value(ptr) == 6'd11) ? 4'd1 : 4'(script_value(ptr));
  endfunction
`endif

  // First probe slot: low LFSR bits folded into 0..51
  assign cand_s = (lfsr_r[5:0] >= 6'd52) ? (lfsr_r[5:0] - 6'd52) : lfsr_r[5:0];

  // Free-running Galois LFSR that supplies the pseudo-random draw order
  always_ff @(posedge clk) begin
    if (reset) lfsr_r <= SEED;
    else       lfsr_r <= {1'b0, lfsr_r[15:1]} ^ (lfsr_r[0] ? 16'hB400 : 16'h0000);
  end

  // Next-state and bookkeeping; shuffle overrides everything, including a draw in flight
  always_comb begin
    state_s      = state_r;
    idx_s        = idx_r;
    mask_s       = mask_r;
    left_s       = left_r;
    pend_rank_s  = pend_rank_r;
    pend_suit_s  = pend_suit_r;
    pend_value_s = pend_value_r;
    rank_s       = rank_r;
    suit_s       = suit_r;
    value_s      = value_r;
    valid_s      = 1'b0;
    busy_s       = busy_r;
    resh_s       = 1'b0;
`ifdef SCRIPTED_DECK_EN
    ptr_s        = ptr_r;
`endif
    if (shuffle) begin
      state_s = IDLE;
      mask_s  = 52'd0;
      left_s  = 6'd52;
      busy_s  = 1'b0;
      resh_s  = 1'b1;
`ifdef SCRIPTED_DECK_EN
      ptr_s   = 3'd0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (req && (left_r != 6'd0)) begin
            idx_s   = cand_s;
            busy_s  = 1'b1;
            state_s = PROBE;
          end else if (req && AUTO_RESHUFFLE) begin
            mask_s  = 52'd0;
            left_s  = 6'd52;
            resh_s  = 1'b1;
            idx_s   = cand_s;
            busy_s  = 1'b1;
            state_s = PROBE;
          end else begin
            state_s = IDLE;
          end
        end
        PROBE: begin
`ifdef SCRIPTED_DECK_EN
          pend_value_s = script_value(ptr_r);
          pend_rank_s  = script_rank(ptr_r);
          pend_suit_s  = 2'd0;
          ptr_s        = ptr_r + 3'd1;
          left_s       = left_r - 6'd1;
          state_s      = DELIVER;
`else
          if (!mask_r[idx_r]) begin
            mask_s[idx_r] = 1'b1;
            left_s        = left_r - 6'd1;
            pend_suit_s   = suit_of(idx_r);
            pend_rank_s   = rank_of(idx_r);
            pend_value_s  = value_of(rank_of(idx_r));
            state_s       = DELIVER;
          end else begin
            // Linear probe to the next slot, wrapping past the last card
            idx_s = (idx_r == 6'd51) ? 6'd0 : (idx_r + 6'd1);
          end
`endif
        end
        DELIVER: begin
          valid_s = 1'b1;
          busy_s  = 1'b0;
          rank_s  = pend_rank_r;
          suit_s  = pend_suit_r;
          value_s = pend_value_r;
          state_s = IDLE;
        end
        default: begin
          busy_s  = 1'b0;
          state_s = IDLE;
        end
      endcase
    end
  end

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      idx_r        <= 6'd0;
      mask_r       <= 52'd0;
      left_r       <= 6'd52;
      pend_rank_r  <= 4'd0;
      pend_suit_r  <= 2'd0;
      pend_value_r <= 6'd0;
      rank_r       <= 4'd0;
      suit_r       <= 2'd0;
      value_r      <= 6'd0;
      valid_r      <= 1'b0;
      busy_r       <= 1'b0;
      resh_r       <= 1'b0;
`ifdef SCRIPTED_DECK_EN
      ptr_r        <= 3'd0;
`endif
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      mask_r       <= mask_s;
      left_r       <= left_s;
      pend_rank_r  <= pend_rank_s;
      pend_suit_r  <= pend_suit_s;
      pend_value_r <= pend_value_s;
      rank_r       <= rank_s;
      suit_r       <= suit_s;
      value_r      <= value_s;
      valid_r      <= valid_s;
      busy_r       <= busy_s;
      resh_r       <= resh_s;
`ifdef SCRIPTED_DECK_EN
      ptr_r        <= ptr_s;
`endif
    end
  end

  assign card_valid = valid_r;
  assign card_value = value_r;
  assign card_rank  = rank_r;
  assign card_suit  = suit_r;
  assign busy       = busy_r;
  assign cards_left = left_r;
  assign reshuffled = resh_r;

endmodule
